ssd1306_spi_sink: RTL

Synthesizable SSD1306 device-side model. It receives the 4-wire SPI stream (din/cs/dc/rst) produced by the display SPI transmitter, deserialises bytes, parses the command set, and converts data bytes into framebuffer write strobes with SSD1306 address auto-increment. It sits on the display side of the link, feeding a 128x64 (8 pages x 128 columns) GDDRAM model used for on-FPGA loopback and simulation checking.

---
 rtl/ssd1306_spi_sink_if.sv | 25 ++
 rtl/ssd1306_spi_sink.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_sink_if.sv
// Display-side link bundle: 4-wire SPI stream in, framebuffer write strobes out.
interface ssd1306_spi_sink_if;
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned BYTE_W = 8;

  logic              spi_din;
  logic              spi_cs;
  logic              spi_dc;
  logic              spi_rst;
  logic              fb_we;
  logic [PAGE_W-1:0] fb_page;
  logic [COL_W-1:0]  fb_column;
  logic [BYTE_W-1:0] fb_data;

  modport master (
    output spi_din, spi_cs, spi_dc, spi_rst,
    input  fb_we, fb_page, fb_column, fb_data
  );

  modport slave (
    input  spi_din, spi_cs, spi_dc, spi_rst,
    output fb_we, fb_page, fb_column, fb_data
  );
endinterface

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 device-side model: SPI deserialiser, command parser and GDDRAM
// write-pointer generator with horizontal/vertical/page auto-increment.
module ssd1306_spi_sink #(
  parameter logic [7:0] CONTRAST_RESET = 8'h7F,
  parameter logic [1:0] MEMMODE_RESET  = 2'd2
) (
  input  logic                 clk,
  input  logic                 reset,
  ssd1306_spi_sink_if.slave    bus,
  output logic                 display_on,
  output logic                 invert,
  output logic [7:0]           contrast,
  output logic [1:0]           mem_mode,
  output logic                 frame_done
);
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {IDLE, ARGS} state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   op_q, op_d;
  logic [1:0]          args_left_q, args_left_d;
  logic [BYTE_W-2:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                byte_vld_q, byte_vld_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                byte_dc_q, byte_dc_d;
  logic [COL_W-1:0]    col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PAGE_W-1:0]   page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [1:0]          mem_mode_q, mem_mode_d;
  logic [BYTE_W-1:0]   contrast_q, contrast_d;
  logic                display_on_q, display_on_d, invert_q, invert_d;
  logic                fb_we_q, fb_we_d, frame_done_q, frame_done_d;
  logic [PAGE_W-1:0]   fb_page_q, fb_page_d;
  logic [COL_W-1:0]    fb_col_q, fb_col_d;
  logic [BYTE_W-1:0]   fb_data_q, fb_data_d;

  // Window stepping: natural increment until the end address, then back to start.
  logic                col_wrap_c, page_wrap_c;
  logic [COL_W-1:0]    col_inc_c;
  logic [PAGE_W-1:0]   page_inc_c;

  assign col_wrap_c  = (col_q == col_end_q);
  assign page_wrap_c = (page_q == page_end_q);
  assign col_inc_c   = col_wrap_c  ? col_start_q  : col_q + COL_W'(1);
  assign page_inc_c  = page_wrap_c ? page_start_q : page_q + PAGE_W'(1);

  always_ff @(posedge clk) begin
    if (!reset || !bus.spi_rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      args_left_q  <= '0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      byte_vld_q   <= 1'b0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_W'(127);
      page_start_q <= '0;
      page_end_q   <= PAGE_W'(7);
      mem_mode_q   <= MEMMODE_RESET;
      contrast_q   <= CONTRAST_RESET;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fb_page_q    <= '0;
      fb_col_q     <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      args_left_q  <= args_left_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_vld_q   <= byte_vld_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      mem_mode_q   <= mem_mode_d;
      contrast_q   <= contrast_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      fb_page_q    <= fb_page_d;
      fb_col_q     <= fb_col_d;
      fb_data_q    <= fb_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    args_left_d  = args_left_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_vld_d   = 1'b0;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    mem_mode_d   = mem_mode_q;
    contrast_d   = contrast_q;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    fb_page_d    = fb_page_q;
    fb_col_d     = fb_col_q;
    fb_data_d    = fb_data_q;

    // Deserialiser: deasserted cs discards any partial byte.
    if (bus.spi_cs) begin
      bit_cnt_d = '0;
    end else begin
      sr_d      = {sr_q[BYTE_W-3:0], bus.spi_din};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == CNT_W'(7)) begin
        byte_vld_d = 1'b1;
        byte_d     = {sr_q, bus.spi_din};
        byte_dc_d  = bus.spi_dc;
      end
    end

    if (byte_vld_q) begin
      if (byte_dc_q) begin
        // Data byte also abandons any pending command arguments.
        state_d     = IDLE;
        args_left_d = '0;
        fb_we_d     = 1'b1;
        fb_page_d   = page_q;
        fb_col_d    = col_q;
        fb_data_d   = byte_q;
        case (mem_mode_q)
          2'd0: begin
            col_d = col_inc_c;
            if (col_wrap_c) begin
              page_d       = page_inc_c;
              frame_done_d = page_wrap_c;
            end
          end
          2'd1: begin
            page_d = page_inc_c;
            if (page_wrap_c) begin
              col_d        = col_inc_c;
              frame_done_d = col_wrap_c;
            end
          end
          default: col_d = col_inc_c;
        endcase
      end else if (state_q == ARGS) begin
        args_left_d = args_left_q - 2'd1;
        if (args_left_q == 2'd1) state_d = IDLE;
        case (op_q)
          8'h21: begin
            if (args_left_q == 2'd2) begin
              col_start_d = byte_q[COL_W-1:0];
              col_d       = byte_q[COL_W-1:0];
            end else begin
              col_end_d = byte_q[COL_W-1:0];
            end
          end
          8'h22: begin
            if (args_left_q == 2'd2) begin
              page_start_d = byte_q[PAGE_W-1:0];
              page_d       = byte_q[PAGE_W-1:0];
            end else begin
              page_end_d = byte_q[PAGE_W-1:0];
            end
          end
          8'h20:   mem_mode_d = (byte_q[1:0] == 2'd3) ? 2'd2 : byte_q[1:0];
          8'h81:   contrast_d = byte_q;
          default: ;
        endcase
      end else begin
        op_d = byte_q;
        case (byte_q)
          8'h21, 8'h22: begin
            state_d     = ARGS;
            args_left_d = 2'd2;
          end
          8'h20, 8'h81, 8'hD5, 8'hA8, 8'hD3, 8'h8D, 8'hDA, 8'hD9, 8'hDB: begin
            state_d     = ARGS;
            args_left_d = 2'd1;
          end
          8'hAE:   display_on_d = 1'b0;
          8'hAF:   display_on_d = 1'b1;
          8'hA6:   invert_d     = 1'b0;
          8'hA7:   invert_d     = 1'b1;
          default: begin
            // Page-mode pointer commands; everything else is a no-op.
            if (mem_mode_q == 2'd2) begin
              if (byte_q[7:3] == 5'b10110)
                page_d = byte_q[PAGE_W-1:0];
              else if (byte_q[7:4] == 4'h0)
                col_d = {col_q[COL_W-1:4], byte_q[3:0]};
              else if (byte_q[7:4] == 4'h1)
                col_d = {byte_q[2:0], col_q[3:0]};
            end
          end
        endcase
      end
    end
  end

  assign bus.fb_we     = fb_we_q;
  assign bus.fb_page   = fb_page_q;
  assign bus.fb_column = fb_col_q;
  assign bus.fb_data   = fb_data_q;
  assign display_on    = display_on_q;
  assign invert        = invert_q;
  assign contrast      = contrast_q;
  assign mem_mode      = mem_mode_q;
  assign frame_done    = frame_done_q;
endmodule
